// File: rtl/board_gpi_debounce_if.sv
// Pin-level bundle for board_gpi_debounce: raw pins in, debounced levels,
// edge pulses and edge-capture/interrupt status out.
interface board_gpi_debounce_if #(
  parameter int GpiWidth = 8
);
  logic [GpiWidth-1:0] gp_raw_i;
  logic [GpiWidth-1:0] gp_o;
  logic [GpiWidth-1:0] rise_o;
  logic [GpiWidth-1:0] fall_o;
  logic [GpiWidth-1:0] rise_en_i;
  logic [GpiWidth-1:0] fall_en_i;
  logic [GpiWidth-1:0] clear_i;
  logic [GpiWidth-1:0] irq_mask_i;
  logic [GpiWidth-1:0] pending_o;
  logic                irq_o;

  modport master (
    output gp_raw_i, rise_en_i, fall_en_i, clear_i, irq_mask_i,
    input  gp_o, rise_o, fall_o, pending_o, irq_o
  );

  modport slave (
    input  gp_raw_i, rise_en_i, fall_en_i, clear_i, irq_mask_i,
    output gp_o, rise_o, fall_o, pending_o, irq_o
  );
endinterface

// File: rtl/board_gpi_debounce.sv
// Per-channel synchroniser + debounce counter for board GPIs, with optional
// edge capture and level interrupt enabled by macro GPI_EDGE_IRQ_EN.
module board_gpi_debounce #(
  parameter int GpiWidth       = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 250000
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  board_gpi_debounce_if.slave  bus
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [GpiWidth-1:0] r_sync [SyncStages];
  logic [CntW-1:0]     r_cnt  [GpiWidth];
  logic [GpiWidth-1:0] r_stable;
  logic [GpiWidth-1:0] r_stable_q;

  logic [GpiWidth-1:0] w_sync;
  logic [CntW-1:0]     w_cnt_next [GpiWidth];
  logic [GpiWidth-1:0] w_stable_next;

  // NOTE: the synchroniser is an array, but it is still reset explicitly so a
  // pin held through reset restarts the full latency instead of leaking in early.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      for (int k = 0; k < SyncStages; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.gp_raw_i;
      for (int k = 1; k < SyncStages; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SyncStages-1];

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch can be inferred.
  always_comb begin
    w_stable_next = r_stable;
    for (int i = 0; i < GpiWidth; i++) begin
      w_cnt_next[i] = '0;
      if (w_sync[i] != r_stable[i]) begin
        if (r_cnt[i] == CntMax) w_stable_next[i] = w_sync[i];
        else                    w_cnt_next[i]    = r_cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < GpiWidth; i++) r_cnt[i] <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
    end else begin
      for (int i = 0; i < GpiWidth; i++) r_cnt[i] <= w_cnt_next[i];
      r_stable   <= w_stable_next;
      r_stable_q <= r_stable;
    end
  end

  // Pulses span the first cycle in which the new stable level is visible.
  assign bus.gp_o   = r_stable;
  assign bus.rise_o = r_stable & ~r_stable_q;
  assign bus.fall_o = ~r_stable & r_stable_q;

`ifdef GPI_EDGE_IRQ_EN
  logic [GpiWidth-1:0] r_pending;
  logic                r_irq;
  logic [GpiWidth-1:0] w_set;

  assign w_set = (bus.rise_o & bus.rise_en_i) | (bus.fall_o & bus.fall_en_i);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      // A capture in the same cycle as its clear must not be lost.
      r_pending <= (r_pending & ~bus.clear_i) | w_set;
      r_irq     <= |(r_pending & bus.irq_mask_i);
    end
  end

  assign bus.pending_o = r_pending;
  assign bus.irq_o     = r_irq;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^{bus.rise_en_i, bus.fall_en_i, bus.clear_i, bus.irq_mask_i};
  assign bus.pending_o = '0;
  assign bus.irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_board_gpi_debounce.sv
// Directed bench for board_gpi_debounce (GpiWidth=8, SyncStages=2,
// DebounceCycles=4); expectations follow GPI_EDGE_IRQ_EN when defined.
module tb_board_gpi_debounce;

  localparam int W = 8;
`ifdef GPI_EDGE_IRQ_EN
  localparam bit EdgeIrq = 1'b1;
`else
  localparam bit EdgeIrq = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] acc;

  board_gpi_debounce_if #(.GpiWidth(W)) bus ();

  board_gpi_debounce #(
    .GpiWidth(W), .SyncStages(2), .DebounceCycles(4)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.gp_raw_i   = '0;
    bus.rise_en_i  = '0;
    bus.fall_en_i  = '0;
    bus.clear_i    = '0;
    bus.irq_mask_i = '0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("reset_gp",      32'(bus.gp_o),      32'h0);
    check("reset_rise",    32'(bus.rise_o),    32'h0);
    check("reset_fall",    32'(bus.fall_o),    32'h0);
    check("reset_pending", 32'(bus.pending_o), 32'h0);
    check("reset_irq",     32'(bus.irq_o),     32'h0);

    // Channel 0 rises; accepted at edge 6 with rise capture and interrupt.
    bus.rise_en_i  = 8'h01;
    bus.irq_mask_i = 8'h01;
    bus.gp_raw_i   = 8'h01;
    step(5);
    check("ch0_edge5_gp",   32'(bus.gp_o),   32'h00);
    check("ch0_edge5_rise", 32'(bus.rise_o), 32'h00);
    step(1);
    check("ch0_edge6_gp",   32'(bus.gp_o),   32'h01);
    check("ch0_edge6_rise", 32'(bus.rise_o), 32'h01);
    check("ch0_edge6_fall", 32'(bus.fall_o), 32'h00);
    step(1);
    check("ch0_edge7_rise",    32'(bus.rise_o),    32'h00);
    check("ch0_edge7_pending", 32'(bus.pending_o), EdgeIrq ? 32'h01 : 32'h00);
    check("ch0_edge7_irq",     32'(bus.irq_o),     32'h0);
    step(1);
    check("ch0_edge8_irq", 32'(bus.irq_o), EdgeIrq ? 32'h1 : 32'h0);

    // Clear alone: pending drops next edge, irq one edge later.
    bus.clear_i = 8'h01;
    step(1);
    bus.clear_i = 8'h00;
    check("clr_pending",  32'(bus.pending_o), 32'h00);
    check("clr_irq_late", 32'(bus.irq_o),     EdgeIrq ? 32'h1 : 32'h0);
    step(1);
    check("clr_irq", 32'(bus.irq_o), 32'h0);

    // Channel 0 falls with fall capture disabled.
    bus.gp_raw_i = 8'h00;
    step(5);
    check("fall_edge5_gp", 32'(bus.gp_o), 32'h01);
    step(1);
    check("fall_edge6_gp",   32'(bus.gp_o),   32'h00);
    check("fall_edge6_fall", 32'(bus.fall_o), 32'h01);
    check("fall_edge6_rise", 32'(bus.rise_o), 32'h00);
    step(1);
    check("fall_edge7_fall",    32'(bus.fall_o),    32'h00);
    check("fall_edge7_pending", 32'(bus.pending_o), 32'h00);

    // Rise again with clear presented in the rise cycle: set wins.
    bus.gp_raw_i = 8'h01;
    step(6);
    check("rise2_rise", 32'(bus.rise_o), 32'h01);
    bus.clear_i = 8'h01;
    step(1);
    bus.clear_i = 8'h00;
    check("setwins_pending", 32'(bus.pending_o), EdgeIrq ? 32'h01 : 32'h00);
    check("setwins_irq0",    32'(bus.irq_o),     32'h0);
    step(1);
    check("setwins_irq1", 32'(bus.irq_o), EdgeIrq ? 32'h1 : 32'h0);

    // Channel 3 glitch of three cycles: counter reaches 3 but never accepts.
    bus.gp_raw_i = 8'h09;
    step(3);
    bus.gp_raw_i = 8'h01;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      acc = acc | bus.gp_o | bus.rise_o | bus.fall_o;
    end
    check("glitch_ch3_activity", 32'(acc & 8'h08), 32'h00);
    check("glitch_gp",           32'(bus.gp_o),    32'h01);

    // Pins 8'hA5 high through reset release.
    bus.rise_en_i  = 8'h00;
    bus.irq_mask_i = 8'h00;
    rst_n = 1'b0;
    bus.gp_raw_i = 8'hA5;
    step(2);
    check("rstA5_gp",      32'(bus.gp_o),      32'h00);
    check("rstA5_fall",    32'(bus.fall_o),    32'h00);
    check("rstA5_pending", 32'(bus.pending_o), 32'h00);
    check("rstA5_irq",     32'(bus.irq_o),     32'h0);
    rst_n = 1'b1;
    step(5);
    check("A5_edge5_gp", 32'(bus.gp_o), 32'h00);
    step(1);
    check("A5_edge6_gp",   32'(bus.gp_o),   32'hA5);
    check("A5_edge6_rise", 32'(bus.rise_o), 32'hA5);
    step(1);
    check("A5_edge7_rise", 32'(bus.rise_o), 32'h00);
    check("A5_edge7_gp",   32'(bus.gp_o),   32'hA5);

    // Reset mid-count on channel 5 discards the count; latency restarts.
    rst_n = 1'b0;
    bus.gp_raw_i = 8'h00;
    step(2);
    rst_n = 1'b1;
    bus.gp_raw_i = 8'h20;
    step(4);
    check("ch5_cnt2_gp", 32'(bus.gp_o), 32'h00);
    rst_n = 1'b0;
    step(1);
    check("ch5_rst_gp",   32'(bus.gp_o),   32'h00);
    check("ch5_rst_rise", 32'(bus.rise_o), 32'h00);
    check("ch5_rst_fall", 32'(bus.fall_o), 32'h00);
    rst_n = 1'b1;
    step(5);
    check("ch5_edge5_gp",   32'(bus.gp_o),   32'h00);
    check("ch5_edge5_rise", 32'(bus.rise_o), 32'h00);
    step(1);
    check("ch5_edge6_gp",   32'(bus.gp_o),   32'h20);
    check("ch5_edge6_rise", 32'(bus.rise_o), 32'h20);
    step(1);
    check("ch5_edge7_rise",    32'(bus.rise_o),    32'h00);
    check("ch5_edge7_pending", 32'(bus.pending_o), 32'h00);
    check("ch5_edge7_irq",     32'(bus.irq_o),     32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
